control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multi-cycle sequencer for the 8-bit accumulator CPU.
- Fetches instructions from the shared memory over a req/ack handshake, decodes them, fetches operands, and drives the ALU function code and the accumulator load strobe.
- It is the producer of the 2-bit ALU function code: ADD=00, SUB=01, PASS=10, ZERO=11.
- Sits between program/data memory and the ALU/accumulator datapath.

Parameters:
- ADDR_W, 5, memory address width; also PC width.
- DATA_W, 8, instruction and data width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack=1.
- mem_ack  in  1  memory completes the current request. Sampled on the clk edge while mem_req=1. May be asserted in the same cycle as mem_req.
- acc_zero  in  1  accumulator equals 0.
- mem_req  out  1  memory request.
- mem_we  out  1  write qualifier; 1 only together with mem_req in STORE.
- mem_addr  out  ADDR_W  request address.
- alu_in1  out  DATA_W  registered operand to ALU in1. ALU in2 is the accumulator.
- alu_func  out  2  ALU function code.
- acc_load  out  1  accumulator captures alu_out at the end of this cycle.
- pc  out  ADDR_W  program counter.
- halted  out  1  core stopped.

Behaviour:
- Instruction format: opcode = ir[7:5], operand address = ir[4:0].
- Opcodes:
  - 000 ADD: acc <= M + acc
  - 001 SUB: acc <= M - acc
  - 010 LDA: acc <= M, via PASS
  - 011 CLR: acc <= 0
  - 100 STA: M <= acc; write data comes from the accumulator outside this block
  - 101 JMP: pc <= addr
  - 110 JZ: pc <= addr if acc_zero
  - 111 HLT
- States: FETCH, DECODE, OPERAND, EXEC, WB, STORE, HALT. Encoded in cpu_pkg.
- FETCH:
  - Outputs: mem_req=1, mem_addr=pc.
  - On ack: ir <= mem_rdata, pc <= pc+1 (wraps 31->0), go to DECODE.
  - Without ack: stay, outputs held.
- DECODE (1 cycle):
  - ADD/SUB/LDA -> OPERAND; CLR -> EXEC; STA -> STORE.
  - JMP -> FETCH with pc <= ir[4:0].
  - JZ -> FETCH with pc <= ir[4:0] if acc_zero (sampled this cycle), else pc unchanged.
  - HLT -> HALT.
- OPERAND:
  - Outputs: mem_req=1, mem_addr=ir[4:0].
  - On ack: alu_in1 <= mem_rdata, go to EXEC.
- EXEC: alu_func = opcode-mapped code (ADD 00, SUB 01, LDA 10, CLR 11), acc_load=0, go to WB.
- WB: alu_func held at the same code, acc_load=1 for exactly one cycle, go to FETCH.
- STORE:
  - Outputs: mem_req=1, mem_we=1, mem_addr=ir[4:0].
  - On ack: go to FETCH.
- HALT: halted=1; all strobes 0; the block stays here until reset.
- alu_func is 11 in every state except EXEC/WB. The ALU evaluates only on a func change, so this idle code guarantees a transition for every ADD/SUB/LDA.
- Minimum cycle counts with zero-wait ack: ADD/SUB/LDA 5; CLR 4; STA 3; JMP/JZ 2.
- Handshake rules:
  - mem_req is registered state-decoded: it is driven from the state register, not combinationally from mem_ack.
  - It drops the cycle after ack, or stays high if the next state also requests (STORE/OPERAND -> FETCH is allowed back-to-back).
  - mem_ack while mem_req=0 is ignored.
  - mem_addr is stable for the whole request.
- Reset (any state, including mid-handshake):
  - Next edge: state=FETCH, pc=0, ir=0, alu_in1=0.
  - Outputs: mem_req=0, mem_we=0, alu_func=11, acc_load=0, halted=0.
  - While reset is high, all outputs are held at these values.
  - The first fetch request appears the cycle after reset deasserts.
  - An outstanding memory transaction is abandoned; the memory must tolerate the req drop.
- Arithmetic: no width growth. SUB wraps modulo 256. PC wraps modulo 32.

Decomposition:
- cpu_pkg:
  - opcode localparams: OP_ADD … OP_HLT.
  - ALU func localparams: F_ADD=00, F_SUB=01, F_PASS=10, F_ZERO=11.
  - FSM state encoding.
  - Opcode-to-func mapping function.
- No sub-module: one FSM plus PC/IR/operand registers in a single module, roughly 150–250 lines.

Test Plan:
- Program ADD: mem[0]=0x0A (ADD 10), mem[10]=0x05, acc=3, zero-wait ack. Required: alu_in1=0x05; alu_func 11→00 in EXEC; acc_load high one cycle, 5 cycles after the first req; pc=1.
- SUB wrap: mem[0]=0x2B (SUB 11), mem[11]=0x02, acc=0x04. Required: alu_func=01; result 0xFE captured.
- Wait states: FETCH ack delayed 3 cycles. Required: mem_req and mem_addr=0 stable for 4 cycles; ir loads only on the ack edge.
- Branches: JZ 0x1F with acc_zero=1 → pc=31, then fetch at 31 and pc wraps to 0. Same with acc_zero=0 → pc=next sequential. JMP 0x05 → next fetch addr=5, 2 cycles.
- STA/HLT: STA 0x12 → mem_req=mem_we=1, addr=0x12. HLT → halted=1, no further mem_req for 20 cycles.
- Reset mid-OPERAND with req pending. Required: next edge mem_req=0, pc=0, alu_func=11; after release, fetch from address 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the accumulator CPU sequencer
// Purpose: opcode, ALU function and FSM state encodings, plus the
//          opcode-to-ALU-function mapping used by control_unit.
// Ports:   none (package).
package cpu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_CLR = 3'b011;
    localparam logic [2:0] OP_STA = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [1:0] F_ADD  = 2'b00;
    localparam logic [1:0] F_SUB  = 2'b01;
    localparam logic [1:0] F_PASS = 2'b10;
    localparam logic [1:0] F_ZERO = 2'b11;

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_OPERAND = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_STORE   = 3'd5;
    localparam logic [2:0] S_HALT    = 3'd6;

    // Only ADD/SUB/LDA need a real ALU operation; everything else (CLR
    // included) uses the ZERO code, which doubles as the idle code.
    function automatic logic [1:0] op_to_func(input logic [2:0] op);
        case (op)
            OP_ADD:  return F_ADD;
            OP_SUB:  return F_SUB;
            OP_LDA:  return F_PASS;
            default: return F_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/execute sequencer
// Purpose: fetches instructions over a req/ack memory handshake, decodes
//          them, fetches operands and drives the ALU function code and
//          the accumulator load strobe.
// Ports:   i_clk, i_reset (sync, active high)
//          i_mem_rdata/i_mem_ack  memory read data and completion
//          i_acc_zero             accumulator equals zero
//          o_mem_req/o_mem_we/o_mem_addr  memory request
//          o_alu_in1/o_alu_func   ALU operand and function code
//          o_acc_load             accumulator capture strobe
//          o_pc, o_halted         program counter, core stopped
module control_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack,
    input  logic              i_acc_zero,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_alu_in1,
    output logic [1:0]        o_alu_func,
    output logic              o_acc_load,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_halted
);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_alu_in1;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [1:0]        r_alu_func;
    logic              r_acc_load;
    logic              r_halted;

    logic [2:0]        w_state_next;
    logic [ADDR_W-1:0] w_pc_next;
    logic [DATA_W-1:0] w_ir_next;
    logic [DATA_W-1:0] w_alu_in1_next;
    logic [2:0]        w_opcode;
    logic [ADDR_W-1:0] w_operand;
    logic              w_ack;
    logic              w_next_req;

    assign w_opcode  = r_ir[DATA_W-1 -: 3];
    assign w_operand = r_ir[ADDR_W-1:0];

    // The state is FETCH during the cycle right after reset release, but
    // no request is out yet; gating with the registered request keeps a
    // stray ack from being taken as a completed fetch.
    assign w_ack = i_mem_ack & r_mem_req;

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_ir_next      = r_ir;
        w_alu_in1_next = r_alu_in1;
        case (r_state)
            S_FETCH: begin
                if (w_ack) begin
                    w_ir_next    = i_mem_rdata;
                    w_pc_next    = r_pc + ADDR_W'(1);
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_opcode)
                    OP_ADD, OP_SUB, OP_LDA: w_state_next = S_OPERAND;
                    OP_CLR:                 w_state_next = S_EXEC;
                    OP_STA:                 w_state_next = S_STORE;
                    OP_JMP: begin
                        w_pc_next    = w_operand;
                        w_state_next = S_FETCH;
                    end
                    OP_JZ: begin
                        if (i_acc_zero) begin
                            w_pc_next = w_operand;
                        end
                        w_state_next = S_FETCH;
                    end
                    default:                w_state_next = S_HALT;
                endcase
            end
            S_OPERAND: begin
                if (w_ack) begin
                    w_alu_in1_next = i_mem_rdata;
                    w_state_next   = S_EXEC;
                end
            end
            S_EXEC:  w_state_next = S_WB;
            S_WB:    w_state_next = S_FETCH;
            S_STORE: begin
                if (w_ack) begin
                    w_state_next = S_FETCH;
                end
            end
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_FETCH;
        endcase
    end

    assign w_next_req = (w_state_next == S_FETCH) ||
                        (w_state_next == S_OPERAND) ||
                        (w_state_next == S_STORE);

    // Outputs are registered from the next state so each one is a clean
    // flop decode of the state being entered; mem_req therefore never
    // depends combinationally on mem_ack.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_FETCH;
            r_pc       <= '0;
            r_ir       <= '0;
            r_alu_in1  <= '0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_alu_func <= F_ZERO;
            r_acc_load <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_ir       <= w_ir_next;
            r_alu_in1  <= w_alu_in1_next;
            r_mem_req  <= w_next_req;
            r_mem_we   <= (w_state_next == S_STORE);
            r_mem_addr <= (w_state_next == S_FETCH) ? w_pc_next
                                                    : w_ir_next[ADDR_W-1:0];
            // ZERO is the idle code so every ADD/SUB/LDA produces a func
            // change on entry to EXEC, which is what triggers the ALU.
            r_alu_func <= ((w_state_next == S_EXEC) || (w_state_next == S_WB))
                          ? op_to_func(w_ir_next[DATA_W-1 -: 3]) : F_ZERO;
            r_acc_load <= (w_state_next == S_WB);
            r_halted   <= (w_state_next == S_HALT);
        end
    end

    assign o_mem_req  = r_mem_req;
    assign o_mem_we   = r_mem_we;
    assign o_mem_addr = r_mem_addr;
    assign o_alu_in1  = r_alu_in1;
    assign o_alu_func = r_alu_func;
    assign o_acc_load = r_acc_load;
    assign o_pc       = r_pc;
    assign o_halted   = r_halted;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       acc_zero;
    logic       mem_req;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] alu_in1;
    logic [1:0] alu_func;
    logic       acc_load;
    logic [4:0] pc;
    logic       halted;

    always #5 clk = ~clk;

    control_unit #(.ADDR_W(5), .DATA_W(8)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_mem_rdata (mem_rdata),
        .i_mem_ack   (mem_ack),
        .i_acc_zero  (acc_zero),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_alu_in1   (alu_in1),
        .o_alu_func  (alu_func),
        .o_acc_load  (acc_load),
        .o_pc        (pc),
        .o_halted    (halted)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  mem [0:31];
    logic [7:0]  acc;
    int          ack_wait;
    int          wcnt;
    logic        stray_ack;
    int          cyc;
    int          first_req;
    int          last_load;
    int          load_cnt;
    logic [31:0] exp_acc_q [$];
    logic [31:0] exp_wr_q  [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] acc_ev(input logic [1:0] f, input logic [7:0] in1, input logic [7:0] res);
        return {14'd0, f, in1, res};
    endfunction

    // One cycle: memory responder, accumulator/ALU model and scoreboard pops,
    // all evaluated at the falling edge, away from the DUT's active edge.
    task automatic tick();
        logic [7:0] nv;
        @(negedge clk);
        cyc++;
        if (mem_req === 1'b1) begin
            if (first_req < 0) first_req = cyc;
            if (wcnt < ack_wait) begin
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
                wcnt++;
            end else begin
                mem_ack   = 1'b1;
                wcnt      = 0;
                mem_rdata = mem[mem_addr];
                if (mem_we === 1'b1) begin
                    if (exp_wr_q.size() == 0) chk("sb_wr_unexpected", exp_wr_q.size(), 1);
                    else chk("sb_wr", {19'd0, mem_addr, acc}, exp_wr_q.pop_front());
                    mem[mem_addr] = acc;
                end
            end
        end else begin
            wcnt      = 0;
            mem_ack   = stray_ack;
            mem_rdata = 8'hE0;
        end
        if (acc_load === 1'b1) begin
            case (alu_func)
                2'b00:   nv = alu_in1 + acc;
                2'b01:   nv = alu_in1 - acc;
                2'b10:   nv = alu_in1;
                default: nv = 8'h00;
            endcase
            if (exp_acc_q.size() == 0) chk("sb_acc_unexpected", exp_acc_q.size(), 1);
            else chk("sb_acc", acc_ev(alu_func, alu_in1, nv), exp_acc_q.pop_front());
            acc = nv;
            load_cnt++;
            last_load = cyc;
        end
        acc_zero = (acc == 8'h00);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 8'hE0;
    endtask

    task automatic start();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cyc = 0; first_req = -1; last_load = -1; load_cnt = 0;
    endtask

    initial begin
        int nreq;
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00; acc = 8'h00; acc_zero = 1'b1;
        ack_wait = 0; wcnt = 0; stray_ack = 1'b1;
        cyc = 0; first_req = -1; last_load = -1; load_cnt = 0;
        clear_mem();

        tick();
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_func", alu_func, 2'b11);
        chk("rst_load", acc_load, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 0);
        chk("rst_in1", alu_in1, 0);

        // ADD 10 with acc=3, zero-wait memory
        clear_mem(); mem[0] = 8'h0A; mem[10] = 8'h05; acc = 8'h03;
        exp_acc_q.push_back(acc_ev(2'b00, 8'h05, 8'h08));
        start();
        tick(); chk("add_req", mem_req, 1); chk("add_addr0", mem_addr, 0);
        tick(); chk("add_dec_noreq", mem_req, 0); chk("add_pc1", pc, 1);
        tick(); chk("add_op_addr", mem_addr, 10); chk("add_op_func", alu_func, 2'b11);
        tick(); chk("add_ex_func", alu_func, 2'b00); chk("add_ex_in1", alu_in1, 8'h05);
                chk("add_ex_noload", acc_load, 0);
        tick(); chk("add_wb_load", acc_load, 1); chk("add_wb_func", alu_func, 2'b00);
                chk("add_lat", last_load - first_req, 4);
        tick(); chk("add_load_once", acc_load, 0); chk("add_func_idle", alu_func, 2'b11);
                chk("add_next_addr", mem_addr, 1); chk("add_pc_end", pc, 1);
        repeat (5) tick();
        chk("add_acc", acc, 8'h08); chk("add_halt", halted, 1);

        // SUB wraps modulo 256
        clear_mem(); mem[0] = 8'h2B; mem[11] = 8'h02; acc = 8'h04;
        exp_acc_q.push_back(acc_ev(2'b01, 8'h02, 8'hFE));
        start();
        repeat (10) tick();
        chk("sub_acc", acc, 8'hFE); chk("sub_loads", load_cnt, 1);

        // fetch ack delayed by 3 cycles, CLR instruction
        clear_mem(); mem[0] = 8'h60; acc = 8'h55; ack_wait = 3;
        exp_acc_q.push_back(acc_ev(2'b11, 8'h00, 8'h00));
        start();
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("ws_req_%0d", i), mem_req, 1);
            chk($sformatf("ws_addr_%0d", i), mem_addr, 0);
            chk($sformatf("ws_pc_%0d", i), pc, 0);
        end
        tick(); chk("ws_drop", mem_req, 0); chk("ws_pc_after", pc, 1);
        repeat (15) tick();
        chk("clr_acc", acc, 8'h00); chk("clr_loads", load_cnt, 1);
        ack_wait = 0;

        // JZ taken to 31, LDA at 31 wraps pc to 0, JZ not taken, HLT
        clear_mem(); mem[0] = 8'hDF; mem[31] = 8'h44; mem[4] = 8'h77; acc = 8'h00;
        exp_acc_q.push_back(acc_ev(2'b10, 8'h77, 8'h77));
        start();
        tick(); chk("jz_addr0", mem_addr, 0);
        tick(); chk("jz_dec_pc", pc, 1);
        tick(); chk("jz_taken_addr", mem_addr, 31); chk("jz_taken_pc", pc, 31); chk("jz_req", mem_req, 1);
        tick(); chk("jz_pc_wrap", pc, 0);
        repeat (6) tick();
        chk("jz_nt_req", mem_req, 1); chk("jz_nt_addr", mem_addr, 1);
        repeat (10) tick();
        chk("jz_halt", halted, 1); chk("jz_pc_final", pc, 2); chk("jz_acc", acc, 8'h77);

        // JMP 5
        clear_mem(); mem[0] = 8'hA5; acc = 8'h01;
        start();
        tick(); tick();
        tick(); chk("jmp_addr", mem_addr, 5); chk("jmp_pc", pc, 5); chk("jmp_req", mem_req, 1);
        repeat (4) tick();
        chk("jmp_halt", halted, 1); chk("jmp_pc_end", pc, 6);

        // STA 0x12 then HLT
        clear_mem(); mem[0] = 8'h92; acc = 8'h3C;
        exp_wr_q.push_back({19'd0, 5'h12, 8'h3C});
        start();
        tick(); tick();
        tick(); chk("sta_req", mem_req, 1); chk("sta_we", mem_we, 1); chk("sta_addr", mem_addr, 5'h12);
        tick(); chk("sta_b2b_req", mem_req, 1); chk("sta_we_off", mem_we, 0); chk("sta_next_addr", mem_addr, 1);
        tick(); tick();
        chk("hlt_halted", halted, 1);
        nreq = 0;
        repeat (20) begin
            tick();
            if (mem_req !== 1'b0 || acc_load !== 1'b0) nreq++;
        end
        chk("hlt_quiet", nreq, 0); chk("hlt_stay", halted, 1);
        chk("sta_mem", mem[5'h12], 8'h3C);

        // reset during a pending OPERAND request
        clear_mem(); mem[0] = 8'h0A; mem[10] = 8'h05; acc = 8'h03; ack_wait = 5;
        start();
        repeat (8) tick();
        chk("rmo_req", mem_req, 1); chk("rmo_addr", mem_addr, 10); chk("rmo_pc", pc, 1);
        reset = 1'b1;
        tick();
        chk("rmo_rst_req", mem_req, 0); chk("rmo_rst_pc", pc, 0); chk("rmo_rst_func", alu_func, 2'b11);
        chk("rmo_rst_we", mem_we, 0); chk("rmo_rst_load", acc_load, 0); chk("rmo_rst_in1", alu_in1, 0);
        tick();
        chk("rmo_hold_req", mem_req, 0);
        ack_wait = 0;
        exp_acc_q.push_back(acc_ev(2'b00, 8'h05, 8'h08));
        reset = 1'b0;
        cyc = 0; first_req = -1; load_cnt = 0;
        tick(); chk("rmo_refetch_req", mem_req, 1); chk("rmo_refetch_addr", mem_addr, 0);
        repeat (12) tick();
        chk("rmo_loads", load_cnt, 1); chk("rmo_acc", acc, 8'h08);

        chk("sb_acc_empty", exp_acc_q.size(), 0);
        chk("sb_wr_empty", exp_wr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
